// File: rtl/key_word_sequencer_if.sv
// Keypad input-port bus and assembled-word handshake shared by the sequencer and its environment.
interface key_word_sequencer_if #(
  parameter int DIGITS = 4
);
  logic [3:0]          port_data;
  logic                port_id;
  logic                port_read;
  logic [4*DIGITS-1:0] word;
  logic                word_valid;
  logic                word_ack;
  logic [2:0]          digit_count;

  modport master (
    input  port_data,
    input  word_ack,
    output port_id,
    output port_read,
    output word,
    output word_valid,
    output digit_count
  );

  modport slave (
    output port_data,
    output word_ack,
    input  port_id,
    input  port_read,
    input  word,
    input  word_valid,
    input  digit_count
  );
endinterface

// File: rtl/key_word_sequencer.sv
// Polls a keypad input port and assembles DIGITS key nibbles (or fewer, ended by ENTER_CODE)
// into a word held for a consumer until acknowledged.
module key_word_sequencer #(
  parameter int          DIGITS     = 4,
  parameter logic [3:0]  ENTER_CODE = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   clear_i,
  key_word_sequencer_if.master   bus
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, POLL, FETCH, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   word_q, word_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     cnt_inc;
  logic           is_enter;

  // Shift a nibble in at the bottom; written via a wider temp so DIGITS=1 stays legal.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] w, input logic [3:0] n);
    logic [W+3:0] tmp;
    tmp = {w, n};
    return tmp[W-1:0];
  endfunction

  assign cnt_inc  = cnt_q + 3'd1;
  assign is_enter = (bus.port_data == ENTER_CODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = IDLE;
      word_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i) state_d = POLL;
        end
        POLL: begin
          if (bus.port_data[0]) state_d = FETCH;
          else if (!enable_i)   state_d = IDLE;
        end
        FETCH: begin
          if (!is_enter) begin
            word_d  = shift_in(word_q, bus.port_data);
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == 3'(DIGITS)) ? DONE : POLL;
          end else begin
            // An enter key with nothing typed yet is dropped rather than producing an empty word.
            state_d = (cnt_q != 3'd0) ? DONE : POLL;
          end
        end
        DONE: begin
          if (bus.word_ack) begin
            word_d  = '0;
            cnt_d   = '0;
            state_d = enable_i ? POLL : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs depend on registered state and data only, never directly on inputs.
  always_comb begin
    bus.port_id     = (state_q == FETCH);
    bus.port_read   = (state_q == POLL);
    bus.word_valid  = (state_q == DONE);
    bus.word        = word_q;
    bus.digit_count = cnt_q;
  end

endmodule

// File: tb/tb_key_word_sequencer.sv
// Directed bench for key_word_sequencer with a keypad port model and a word scoreboard.
module tb_key_word_sequencer;

  localparam int DIGITS = 4;

  typedef struct {
    logic [4*DIGITS-1:0] word;
    logic [2:0]          count;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic clear;

  key_word_sequencer_if #(.DIGITS(DIGITS)) bus();

  key_word_sequencer #(.DIGITS(DIGITS), .ENTER_CODE(4'hF)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .clear_i  (clear),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Keypad port model: one key latched at a time, ready cleared by a status read.
  logic [3:0] key_q[$];
  logic [3:0] key_reg = 4'h0;
  logic       ready   = 1'b0;

  assign bus.port_data = bus.port_id ? key_reg : {3'b000, ready};

  always @(posedge clk) begin
    if (bus.port_read && !bus.port_id && ready) begin
      ready <= 1'b0;
    end else if (!ready && !bus.port_id && key_q.size() > 0) begin
      key_reg <= key_q.pop_front();
      ready   <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [4*DIGITS-1:0] w, input logic [2:0] c);
    exp_t e;
    e.word  = w;
    e.count = c;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [3:0] k);
    key_q.push_back(k);
  endtask

  task automatic collect(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.word_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.word_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_word"},  32'(bus.word),        32'(e.word));
      chk({tag, "_count"}, 32'(bus.digit_count), 32'(e.count));
    end else begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic ack_and_check(input string tag);
    bus.word_ack = 1'b1;
    @(negedge clk);
    bus.word_ack = 1'b0;
    chk({tag, "_ack_word"},  32'(bus.word),        32'd0);
    chk({tag, "_ack_count"}, 32'(bus.digit_count), 32'd0);
    chk({tag, "_ack_valid"}, 32'(bus.word_valid),  32'd0);
    chk({tag, "_ack_poll"},  32'(bus.port_read),   32'(enable));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_valid;
    rst          = 1'b1;
    enable       = 1'b0;
    clear        = 1'b0;
    bus.word_ack = 1'b0;

    @(negedge clk);
    chk("rst_port_id",   32'(bus.port_id),     32'd0);
    chk("rst_port_read", 32'(bus.port_read),   32'd0);
    chk("rst_word",      32'(bus.word),        32'd0);
    chk("rst_valid",     32'(bus.word_valid),  32'd0);
    chk("rst_count",     32'(bus.digit_count), 32'd0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_enable", 32'(bus.port_read), 32'd0);

    enable = 1'b1;
    @(negedge clk);
    chk("idle_to_poll", 32'(bus.port_read), 32'd1);

    // Full word
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    expect_word(16'h1234, 3'd4);
    collect("w1234");
    chk("done_no_read", 32'(bus.port_read), 32'd0);
    chk("done_port_id", 32'(bus.port_id),   32'd0);
    ack_and_check("w1234");

    // Early enter
    press(4'h7); press(4'hF);
    expect_word(16'h0007, 3'd1);
    collect("w7F");
    ack_and_check("w7F");

    // Enter as the first key is dropped
    press(4'hF);
    repeat (10) @(negedge clk);
    chk("enter_first_count", 32'(bus.digit_count), 32'd0);
    chk("enter_first_word",  32'(bus.word),        32'd0);
    chk("enter_first_valid", 32'(bus.word_valid),  32'd0);
    chk("enter_first_poll",  32'(bus.port_read),   32'd1);

    // Key arriving while a word is held stays pending
    press(4'h3); press(4'hF); press(4'h5);
    expect_word(16'h0003, 3'd1);
    collect("w3F");
    repeat (5) @(negedge clk);
    chk("held_word",  32'(bus.word),       32'h0003);
    chk("held_valid", 32'(bus.word_valid), 32'd1);
    ack_and_check("w3F");
    press(4'h6); press(4'hF);
    expect_word(16'h0056, 3'd2);
    collect("w56");
    ack_and_check("w56");

    // Clear discards a partial word
    press(4'h9); press(4'h8);
    n = 0;
    while (bus.digit_count != 3'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_clear_count", 32'(bus.digit_count), 32'd2);
    chk("pre_clear_word",  32'(bus.word),        32'h0098);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_count", 32'(bus.digit_count), 32'd0);
    chk("clear_word",  32'(bus.word),        32'd0);
    chk("clear_valid", 32'(bus.word_valid),  32'd0);
    chk("clear_idle",  32'(bus.port_read),   32'd0);
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
    expect_word(16'hABCD, 3'd4);
    collect("wABCD");
    ack_and_check("wABCD");

    // Asynchronous reset in the middle of a FETCH cycle
    press(4'h2);
    n = 0;
    while (!bus.port_id && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_reached", 32'(bus.port_id), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_port_id",   32'(bus.port_id),     32'd0);
    chk("async_port_read", 32'(bus.port_read),   32'd0);
    chk("async_word",      32'(bus.word),        32'd0);
    chk("async_valid",     32'(bus.word_valid),  32'd0);
    chk("async_count",     32'(bus.digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.word_valid) saw_valid = 1'b1;
    end
    chk("post_reset_no_valid", 32'(saw_valid),         32'd0);
    chk("post_reset_count",    32'(bus.digit_count),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_word_sequencer.md
KEY_WORD_SEQUENCER -- requirements
Module: key_word_sequencer

Interface
REQ-001 Parameter DIGITS, default 4: number of keypad nibbles per word, legal range 1..7.
REQ-002 Parameter ENTER_CODE, default 4'hF: nibble value that terminates a word early.
REQ-003 Port clock  input  1  single clock for all state; rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port enable  input  1  high permits polling of the keypad input port.
REQ-006 Port clear  input  1  synchronous abort; discards the partial or held word.
REQ-007 Port port_data  input  4  keypad input port read data: status {3'b000, ready} when port_id=0, key nibble when port_id=1.
REQ-008 Port port_id  output  1  port select: 0 = status, 1 = data.
REQ-009 Port port_read  output  1  read strobe; with port_id=0 and ready=1 it clears the port's ready flag at the next edge.
REQ-010 Port word  output  4*DIGITS  assembled word; first key in the most significant nibble.
REQ-011 Port word_valid  output  1  word is complete and held.
REQ-012 Port word_ack  input  1  consumer accepts the word; sampled only while word_valid=1.
REQ-013 Port digit_count  output  3  digits accumulated in the current word.

Function
REQ-014 FSM states IDLE, POLL, FETCH, DONE; all outputs registered or decoded from state only, so there is no combinational path from any input to any output.
REQ-015 IDLE: port_id=0, port_read=0; enable=1 -> POLL next cycle.
REQ-016 POLL: port_id=0, port_read=1.
  - port_data[0]=1 -> FETCH.
  - else enable=0 -> IDLE.
  - else stay in POLL.
REQ-017 FETCH lasts exactly one cycle: port_id=1, port_read=0; port_data captured at the end of the cycle.
REQ-018 FETCH, nibble != ENTER_CODE: word <= {word[4*DIGITS-5:0], nibble}; digit_count increments.
  - new count == DIGITS -> DONE.
  - else -> POLL.
REQ-019 FETCH, nibble == ENTER_CODE:
  - digit_count > 0 -> DONE; word unshifted, right-aligned.
  - digit_count == 0 -> key ignored, return to POLL.
REQ-020 DONE: word_valid=1, port_read=0, port_id=0; word and digit_count held stable; keypad is not polled, so further keys stay pending in the input port.
REQ-021 DONE and word_ack=1: word <= 0, digit_count <= 0, word_valid deasserts next cycle; next state POLL if enable=1, else IDLE.
REQ-022 enable=0 during FETCH or DONE does not abort; it takes effect only at the POLL/IDLE decision.
REQ-023 Latency:
  - key ready observed in POLL -> nibble in word 1 cycle after FETCH.
  - last digit -> word_valid high on the cycle after FETCH.
REQ-024 clear=1 in any state -> IDLE, word=0, digit_count=0, word_valid=0 next cycle; clear has priority over word_ack and enable.
REQ-025 word_ack while word_valid=0 is ignored.
REQ-026 digit_count never exceeds DIGITS; no wrap occurs.

Reset
REQ-027 reset=1 asynchronously forces IDLE, port_id=0, port_read=0, word=0, word_valid=0, digit_count=0.
REQ-028 After reset deassertion the first transition occurs on the next rising clock edge at which enable=1.
REQ-029 Reset asserted mid-word (any state) discards all partial data; no word_valid pulse follows.

Verification
REQ-030 Keys 1,2,3,4 with enable=1 and DIGITS=4 -> word_valid=1, word=16'h1234, digit_count=4; word_ack -> word=0, state POLL.
REQ-031 Keys 7,F -> word_valid=1, word=16'h0007, digit_count=1.
REQ-032 Key F as the first key -> no shift, digit_count stays 0, FSM remains polling.
REQ-033 Key 5 while word_valid=1 -> word unchanged; after word_ack, 5 is fetched as the first digit of the next word.
REQ-034 clear pulse after keys 9,8 -> digit_count=0, word=0, IDLE; next keys start a new word.
REQ-035 Async reset asserted mid-cycle during FETCH -> all outputs zero immediately, without waiting for a clock edge.
